snes_ctrl_tx: RTL and testbench

- Controller-side responder for the SNES serial pad protocol; the transmit counterpart of the snes_igr snooper.
- Drives CONTDOUT toward the console in response to console latch/clock.
- Source is the live pad, an injected 16-bit button word, or both merged; the port can also be blocked.
- Sits between the pad connector and the console on MCLKO (~21.477 MHz).

---
 rtl/snes_ctrl_pkg.sv | 40 ++++
 rtl/snes_ctrl_sync.sv | 32 +++
 rtl/snes_ctrl_tx.sv | 164 ++++++++++++++++
 tb/tb_snes_ctrl_tx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/snes_ctrl_pkg.sv
// Shared encodings for the SNES controller transmit path: modes, FSM states,
// report width, button bit positions and the per-bit output mux.
package snes_ctrl_pkg;

  localparam int CTRL_NBITS = 16;

  localparam logic [1:0] MODE_PASS   = 2'b00;
  localparam logic [1:0] MODE_INJECT = 2'b01;
  localparam logic [1:0] MODE_MERGE  = 2'b10;
  localparam logic [1:0] MODE_BLOCK  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LATCH = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_EXTRA = 2'd3;

  localparam int BTN_B     = 0;
  localparam int BTN_Y     = 1;
  localparam int BTN_SEL   = 2;
  localparam int BTN_START = 3;
  localparam int BTN_UP    = 4;
  localparam int BTN_DOWN  = 5;
  localparam int BTN_LEFT  = 6;
  localparam int BTN_RIGHT = 7;
  localparam int BTN_A     = 8;
  localparam int BTN_X     = 9;
  localparam int BTN_L     = 10;
  localparam int BTN_R     = 11;

  // live is active-low pad data, btn is an active-high injected button
  function automatic logic line_bit(input logic [1:0] mode, input logic live, input logic btn);
    case (mode)
      MODE_PASS:   return live;
      MODE_INJECT: return ~btn;
      MODE_MERGE:  return live & ~btn;
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/snes_ctrl_sync.sv
// SYNC_STAGES-deep synchronizer with one history flop for rise/fall detect.
module snes_ctrl_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b1
) (
  input  logic CLK_i,
  input  logic NRST_i,
  input  logic D_i,
  output logic Q_o,
  output logic RISE_o,
  output logic FALL_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge CLK_i or negedge NRST_i) begin
    if (!NRST_i) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q[0] <= D_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign Q_o    = sync_q[SYNC_STAGES-1];
  assign RISE_o = Q_o & ~hist_q;
  assign FALL_o = ~Q_o & hist_q;

endmodule

// File: rtl/snes_ctrl_tx.sv
// SNES pad responder: drives CONTDOUT from live pad, injected word, or both.
// Optional turbo masking is enabled with `define SNES_CTRL_TX_TURBO_EN.
module snes_ctrl_tx
  import snes_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NBITS       = CTRL_NBITS,
  parameter int TURBO_DIV   = 4
) (
  input  logic             CLK_i,
  input  logic             NRST_i,
`ifdef SNES_CTRL_TX_TURBO_EN
  input  logic [NBITS-1:0] TURBO_MASK_i,
`endif
  input  logic             CTRL_LATCH_i,
  input  logic             CTRL_CLK_i,
  input  logic             CTRL_SDATA_i,
  input  logic [1:0]       MODE_i,
  input  logic [NBITS-1:0] INJ_WORD_i,
  input  logic             INJ_VALID_i,
  output logic             INJ_ACK_o,
  output logic             CTRL_SDATA_o,
  output logic [4:0]       BIT_IDX_o,
  output logic             FRAME_DONE_o
);

  localparam logic [4:0] IDX_MAX  = 5'(NBITS);
  localparam logic [4:0] IDX_LAST = 5'(NBITS - 1);

  logic lat_r, lat_f, clk_r, dat_s;
  logic unused_lat_s, unused_clk_s, unused_clk_f, unused_dat_r, unused_dat_f;

  snes_ctrl_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_lat (
    .CLK_i(CLK_i), .NRST_i(NRST_i), .D_i(CTRL_LATCH_i),
    .Q_o(unused_lat_s), .RISE_o(lat_r), .FALL_o(lat_f));
  snes_ctrl_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_clk (
    .CLK_i(CLK_i), .NRST_i(NRST_i), .D_i(CTRL_CLK_i),
    .Q_o(unused_clk_s), .RISE_o(clk_r), .FALL_o(unused_clk_f));
  snes_ctrl_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_dat (
    .CLK_i(CLK_i), .NRST_i(NRST_i), .D_i(CTRL_SDATA_i),
    .Q_o(dat_s), .RISE_o(unused_dat_r), .FALL_o(unused_dat_f));

  logic [1:0]       state_q, state_d, mode_q, mode_d;
  logic [4:0]       idx_q, idx_d;
  logic [NBITS-1:0] held_q, held_d, pend_q, pend_d, held_sh, load_word;
  logic             pend_vld_q, pend_vld_d;
  logic             sdata_q, sdata_d, ack_q, ack_d, done_q, done_d;
  logic             load;

`ifdef SNES_CTRL_TX_TURBO_EN
  localparam int TCW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;
  logic [NBITS-1:0] base_q, src_word;
  logic [TCW-1:0]   tcnt_q;
  logic             phase_q;

  // base_q keeps the unmasked word so masked bits come back on the next phase
  assign src_word  = pend_vld_q ? pend_q : base_q;
  assign load_word = src_word & (~TURBO_MASK_i | {NBITS{phase_q}});

  always_ff @(posedge CLK_i or negedge NRST_i) begin
    if (!NRST_i) begin
      base_q  <= '0;
      tcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      if (load) base_q <= src_word;
      if (lat_r) begin
        if (tcnt_q == TCW'(TURBO_DIV - 1)) begin
          tcnt_q  <= '0;
          phase_q <= ~phase_q;
        end else begin
          tcnt_q <= tcnt_q + TCW'(1);
        end
      end
    end
  end
`else
  localparam int unused_turbo_div = TURBO_DIV;
  assign load_word = pend_vld_q ? pend_q : held_q;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    held_d     = held_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    mode_d     = mode_q;
    ack_d      = 1'b0;
    done_d     = 1'b0;
    load       = 1'b0;

    case (state_q)
      ST_IDLE, ST_EXTRA: if (lat_r) load = 1'b1;
      ST_LATCH:          if (lat_f) state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (lat_r) begin
          load = 1'b1;
        end else if (clk_r) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = IDX_MAX;
            state_d = ST_EXTRA;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      state_d    = ST_LATCH;
      idx_d      = '0;
      held_d     = load_word;
      pend_vld_d = 1'b0;
    end
    if (state_d == ST_LATCH) mode_d = MODE_i;

    // a slot freed by this cycle's load only accepts a new word next cycle
    if (INJ_VALID_i && !pend_vld_q) begin
      pend_d     = INJ_WORD_i;
      pend_vld_d = 1'b1;
      ack_d      = 1'b1;
    end

    held_sh = held_d >> idx_d;
    case (state_d)
      ST_LATCH, ST_SHIFT: sdata_d = line_bit(mode_d, dat_s, held_sh[0]);
      ST_EXTRA:           sdata_d = (mode_d == MODE_PASS) ? dat_s : (mode_d == MODE_BLOCK);
      default:            sdata_d = (MODE_i == MODE_PASS) ? dat_s : 1'b1;
    endcase
  end

  always_ff @(posedge CLK_i or negedge NRST_i) begin
    if (!NRST_i) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      held_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      mode_q     <= MODE_PASS;
      sdata_q    <= 1'b1;
      ack_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      held_q     <= held_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      mode_q     <= mode_d;
      sdata_q    <= sdata_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
    end
  end

  assign CTRL_SDATA_o = sdata_q;
  assign INJ_ACK_o    = ack_q;
  assign BIT_IDX_o    = idx_q;
  assign FRAME_DONE_o = done_q;

endmodule

// File: tb/tb_snes_ctrl_tx.sv
// Scoreboard bench for snes_ctrl_tx: stimulus pushes expected line bits, ACK
// words and frame-done events; monitors pop and compare as the DUT responds.
module tb_snes_ctrl_tx;
  import snes_ctrl_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        latch = 1'b0, cclk = 1'b1;
  logic        sdin;
  logic [1:0]  mode = MODE_PASS;
  logic [15:0] inj_word = '0;
  logic        inj_valid = 1'b0;
  logic        ack, sdout, done;
  logic [4:0]  bidx;

  snes_ctrl_tx dut (
    .CLK_i(clk), .NRST_i(rst_n),
`ifdef SNES_CTRL_TX_TURBO_EN
    .TURBO_MASK_i(16'h0000),
`endif
    .CTRL_LATCH_i(latch), .CTRL_CLK_i(cclk), .CTRL_SDATA_i(sdin),
    .MODE_i(mode), .INJ_WORD_i(inj_word), .INJ_VALID_i(inj_valid),
    .INJ_ACK_o(ack), .CTRL_SDATA_o(sdout), .BIT_IDX_o(bidx), .FRAME_DONE_o(done));

  always #5 clk = ~clk;

  // live pad: active-high pressed buttons, shifted out active-low, 0 after 16 bits
  logic [15:0] pad = '0;
  int          pidx = 16;
  always @(posedge latch or posedge cclk) begin
    if (latch) pidx = 0;
    else if (pidx < 16) pidx++;
  end
  assign sdin = (pidx < 16) ? ~pad[pidx[3:0]] : 1'b0;

  typedef struct {logic line; logic [4:0] idx; int k;} bexp_t;
  bexp_t       bit_q[$];
  int          done_q[$];
  logic [15:0] ack_q[$];
  int          checks = 0, errors = 0;
  bit          mon_en = 1'b0;

  // reference model of what the console should see
  logic [15:0] held_m = '0, pend_m = '0;
  bit          pend_v = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_line(input logic [1:0] m, input int k,
                                    input logic [15:0] p, input logic [15:0] h);
    if (k >= 16) return (m == MODE_BLOCK);
    case (m)
      MODE_PASS:   return !p[k];
      MODE_INJECT: return !h[k];
      MODE_MERGE:  return !(p[k] || h[k]);
      default:     return 1'b1;
    endcase
  endfunction

  always @(posedge cclk) if (mon_en) begin
    if (bit_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL bit_queue: clock edge with no expected bit at %0t", $time);
    end else begin
      bexp_t e;
      e = bit_q.pop_front();
      chk($sformatf("line_k%0d", e.k), 32'(sdout), 32'(e.line));
      chk($sformatf("bit_idx_k%0d", e.k), 32'(bidx), 32'(e.idx));
    end
  end

  always @(negedge clk) if (mon_en) begin
    if (done) begin
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL frame_done: unexpected pulse at %0t", $time);
      end else begin
        void'(done_q.pop_front());
        chk("done_idx", 32'(bidx), 32'd16);
      end
    end
    if (ack) begin
      if (ack_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL inj_ack: unexpected pulse at %0t", $time);
      end else begin
        chk("ack_word", 32'(inj_word), 32'(ack_q.pop_front()));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic offer(input logic [15:0] w);
    @(negedge clk);
    inj_word  = w;
    inj_valid = 1'b1;
    if (!pend_v) begin
      pend_m = w; pend_v = 1'b1; ack_q.push_back(w);
    end
    cyc(5);
    inj_valid = 1'b0;
  endtask

  // one console poll: latch, then nclk clock pulses; rst_at>=0 resets mid-frame
  task automatic frame(input logic [1:0] m, input int nclk, input int rst_at, input logic [15:0] p);
    int h;
    h = $urandom_range(5, 9);
    mode = m;
    pad  = p;
    if (pend_v) begin held_m = pend_m; pend_v = 1'b0; end
    if (inj_valid && !pend_v) begin
      pend_m = inj_word; pend_v = 1'b1; ack_q.push_back(inj_word);
    end
    @(negedge clk);
    latch = 1'b1; cyc(8 + h);
    latch = 1'b0; cyc(h);
    for (int k = 0; k < nclk; k++) begin
      cclk = 1'b0; cyc(h);
      bit_q.push_back('{line: exp_line(m, k, p, held_m), idx: 5'((k > 16) ? 16 : k), k: k});
      if (k == 15) done_q.push_back(1);
      cclk = 1'b1;
      if (k == rst_at) begin
        cyc(h);
        offer(16'hBEEF);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_sdata", 32'(sdout), 32'd1);
        chk("midrst_ack", 32'(ack), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_idx", 32'(bidx), 32'd0);
        held_m = '0; pend_v = 1'b0;
        rst_n = 1'b1;
        cyc(4);
        return;
      end
      if (k == 8) mode = 2'($urandom_range(0, 3));
      cyc(h);
    end
  endtask

  initial begin
    cyc(3);
    chk("rst_sdata", 32'(sdout), 32'd1);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_idx", 32'(bidx), 32'd0);
    rst_n = 1'b1;
    cyc(3);
    mon_en = 1'b1;

    offer(16'h0001);
    frame(MODE_INJECT, 17, -1, 16'h0000);
    offer(16'h0010);
    frame(MODE_MERGE, 17, -1, 16'h0001 << BTN_A);
    frame(MODE_BLOCK, 17, -1, 16'hFFFF);
    frame(MODE_INJECT, 7, -1, 16'(~$urandom()));
    frame(MODE_INJECT, 17, -1, 16'($urandom()));

    // valid held high over three latches, word changed between frames
    @(negedge clk);
    inj_word = 16'hA5C3; inj_valid = 1'b1;
    if (!pend_v) begin pend_m = inj_word; pend_v = 1'b1; ack_q.push_back(inj_word); end
    cyc(5);
    inj_word = 16'h1248;
    frame(MODE_INJECT, 17, -1, 16'($urandom()));
    inj_word = 16'h8421;
    frame(MODE_MERGE, 16, -1, 16'($urandom()));
    inj_word = 16'h0FF0;
    frame(MODE_INJECT, 17, -1, 16'($urandom()));
    inj_valid = 1'b0;

    offer(16'h7777);
    frame(MODE_PASS, 17, 5, 16'($urandom()));
    frame(MODE_INJECT, 17, -1, 16'($urandom()));

    for (int i = 0; i < 12; i++) begin
      int n;
      if ($urandom_range(0, 1) == 1) offer(16'($urandom()));
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 15) : $urandom_range(16, 17);
      frame(2'($urandom_range(0, 3)), n, -1, 16'($urandom()));
    end

    cyc(20);
    chk("bit_q_drained", 32'(bit_q.size()), 32'd0);
    chk("done_q_drained", 32'(done_q.size()), 32'd0);
    chk("ack_q_drained", 32'(ack_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
